// File: rtl/fxp_alu_sequencer_if.sv
// fxp_alu_sequencer_if: operation request and result handshake bundle
// between the keypad FSM (master) and the fixed-point sequencer (slave).
interface fxp_alu_sequencer_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 3;

  logic              op_valid;
  logic              op_ready;
  logic [OP_W-1:0]   op_code;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] result;
  logic              ovf;
  logic              div0;
  logic              busy;

  modport master (
    output op_valid, op_code, op_a, op_b, res_ready,
    input  op_ready, res_valid, result, ovf, div0, busy
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, res_ready,
    output op_ready, res_valid, result, ovf, div0, busy
  );
endinterface

// File: rtl/fxp_alu_sequencer.sv
// fxp_alu_sequencer: multi-cycle signed Q1.9.6 ADD/SUB/MUL/DIV sequencer.
// MUL is a 16-step shift-add, DIV a 23-step restoring divide, both on magnitudes.
// Build option: define FXP_SATURATE_EN to saturate overflowed and divide-by-zero
// results; otherwise overflowed results wrap and divide-by-zero returns 0.
module fxp_alu_sequencer (
  input  logic               clk,
  input  logic               clear,
  fxp_alu_sequencer_if.slave bus
);
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAC_W    = 6;
  localparam int unsigned MAG_W     = DATA_W + 1;
  localparam int unsigned ACC_W     = 2 * MAG_W;
  localparam int unsigned QUO_W     = MAG_W + FRAC_W;
  localparam int unsigned FIN_W     = ACC_W - FRAC_W;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned MUL_ITERS = DATA_W;
  localparam int unsigned DIV_ITERS = QUO_W;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;

  localparam logic [DATA_W-1:0] POS_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] NEG_MAX = 16'h8000;

`ifdef FXP_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q, mcand_q;
  logic [MAG_W-1:0]   mplier_q;   // |op_b|: shifting multiplier for MUL, fixed divisor for DIV
  logic [MAG_W-1:0]   rem_q;
  logic [QUO_W-1:0]   quo_q;
  logic [DATA_W-1:0]  result_q;
  logic               ovf_q, div0_q, res_valid_q, busy_q;

  logic [DATA_W-1:0]  sum, diff, div0_res;
  logic               res_neg, div_ge;
  logic [DATA_W:0]    mul_fin, div_fin;
  logic [MAG_W:0]     div_sh;
  logic               fin_done, fin_ovf, fin_div0;
  logic [DATA_W-1:0]  fin_result;

  // Magnitude in 17 bits so that 0x8000 (-512.0) keeps its full value
  function automatic logic [MAG_W-1:0] mag_of(input logic [DATA_W-1:0] v);
    logic [MAG_W-1:0] ext;
    ext = {v[DATA_W-1], v};
    return v[DATA_W-1] ? MAG_W'(-ext) : ext;
  endfunction

  // Apply sign to a truncated magnitude and range-check it; returns {ovf, result}
  function automatic logic [DATA_W:0] fold_result(input logic [FIN_W-1:0] mag,
                                                  input logic neg);
    logic              ovf;
    logic [DATA_W-1:0] res;
    ovf = neg ? (mag > FIN_W'(NEG_MAX)) : (mag > FIN_W'(POS_MAX));
    res = neg ? DATA_W'(-mag[DATA_W-1:0]) : mag[DATA_W-1:0];
    if (SAT_EN && ovf) res = neg ? NEG_MAX : POS_MAX;
    return {ovf, res};
  endfunction

  // Completion detect and final result/flags for the operation in EXEC
  always_comb begin
    fin_done   = 1'b0;
    fin_ovf    = 1'b0;
    fin_div0   = 1'b0;
    fin_result = '0;
    sum        = a_q + b_q;
    diff       = a_q - b_q;
    res_neg    = a_q[DATA_W-1] ^ b_q[DATA_W-1];
    mul_fin    = fold_result(FIN_W'(acc_q >> FRAC_W), res_neg);
    div_fin    = fold_result(FIN_W'(quo_q), res_neg);
    div_sh     = {rem_q, quo_q[QUO_W-1]};
    div_ge     = div_sh >= {1'b0, mplier_q};
    div0_res   = a_q[DATA_W-1] ? NEG_MAX : ((a_q != '0) ? POS_MAX : '0);
    case (op_q)
      OP_ADD: begin
        fin_done   = 1'b1;
        fin_ovf    = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
        fin_result = (SAT_EN && fin_ovf) ? (a_q[DATA_W-1] ? NEG_MAX : POS_MAX) : sum;
      end
      OP_SUB: begin
        fin_done   = 1'b1;
        fin_ovf    = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
        fin_result = (SAT_EN && fin_ovf) ? (a_q[DATA_W-1] ? NEG_MAX : POS_MAX) : diff;
      end
      OP_MUL: begin
        fin_done              = (cnt_q == CNT_W'(MUL_ITERS));
        {fin_ovf, fin_result} = mul_fin;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          fin_done   = 1'b1;
          fin_div0   = 1'b1;
          fin_result = SAT_EN ? div0_res : '0;
        end else begin
          fin_done              = (cnt_q == CNT_W'(DIV_ITERS));
          {fin_ovf, fin_result} = div_fin;
        end
      end
      default: fin_done = 1'b1;
    endcase
  end

  // Sequencer FSM: accept, iterate/finalize, hold result until consumed
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.op_valid) begin
            op_q     <= bus.op_code;
            a_q      <= bus.op_a;
            b_q      <= bus.op_b;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= ACC_W'(mag_of(bus.op_a));
            mplier_q <= mag_of(bus.op_b);
            rem_q    <= '0;
            quo_q    <= {mag_of(bus.op_a), {FRAC_W{1'b0}}};
            busy_q   <= 1'b1;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (fin_done) begin
            result_q    <= fin_result;
            ovf_q       <= fin_ovf;
            div0_q      <= fin_div0;
            res_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (op_q == OP_MUL) begin
              acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
              mcand_q  <= mcand_q << 1;
              mplier_q <= mplier_q >> 1;
            end else begin
              rem_q <= div_ge ? MAG_W'(div_sh - {1'b0, mplier_q}) : MAG_W'(div_sh);
              quo_q <= {quo_q[QUO_W-2:0], div_ge};
            end
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.op_ready  = (state_q == S_IDLE) && !clear;
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.div0      = div0_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fxp_alu_sequencer.sv
// tb_fxp_alu_sequencer: directed vectors against a transaction-level model of
// the Q1.9.6 sequencer (exact integer arithmetic plus per-op latency).
module tb_fxp_alu_sequencer;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;

`ifdef FXP_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  fxp_alu_sequencer_if bus();

  fxp_alu_sequencer dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Exact arithmetic reference: truncating integer math on the real values
  function automatic void model_op(input logic [2:0] op, input logic [15:0] a, b,
                                   output logic [15:0] r, output logic ov, d0,
                                   output int lat);
    longint sa, sb, q;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    q   = 0;
    d0  = 1'b0;
    lat = 1;
    case (op)
      OP_ADD: q = sa + sb;
      OP_SUB: q = sa - sb;
      OP_MUL: begin q = (sa * sb) / 64; lat = 17; end
      OP_DIV: begin
        if (sb == 0) d0 = 1'b1;
        else begin q = (sa * 64) / sb; lat = 24; end
      end
      default: q = 0;
    endcase
    ov = (q > 32767) || (q < -32768);
    r  = 16'(q);
    if (SAT && ov) r = (q > 0) ? 16'h7FFF : 16'h8000;
    if (SAT && d0) r = (sa > 0) ? 16'h7FFF : ((sa < 0) ? 16'h8000 : 16'h0000);
  endfunction

  // Transaction-level model: pending result appears after its latency
  logic        m_busy  = 1'b0;
  logic        m_valid = 1'b0;
  logic [15:0] m_res   = '0;
  logic        m_ovf   = 1'b0;
  logic        m_div0  = 1'b0;
  logic [15:0] p_res;
  logic        p_ovf, p_div0;
  int          m_left  = 0;

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      m_busy = 1'b0; m_valid = 1'b0; m_res = '0; m_ovf = 1'b0; m_div0 = 1'b0; m_left = 0;
    end else if (!m_busy && bus.op_valid) begin
      model_op(bus.op_code, bus.op_a, bus.op_b, p_res, p_ovf, p_div0, m_left);
      m_busy = 1'b1;
    end else if (m_busy && !m_valid) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1; m_res = p_res; m_ovf = p_ovf; m_div0 = p_div0;
      end
    end else if (m_valid && bus.res_ready) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("op_ready",  bus.op_ready,  (!m_busy && !clear));
    chk("res_valid", bus.res_valid, m_valid);
    chk("busy",      bus.busy,      m_busy);
    chk("result",    bus.result,    m_res);
    chk("ovf",       bus.ovf,       m_ovf);
    chk("div0",      bus.div0,      m_div0);
  end

  task automatic issue(input string tag, input logic [2:0] op, input logic [15:0] a, b);
    bit done;
    done = 1'b0;
    bus.op_valid = 1'b1; bus.op_code = op; bus.op_a = a; bus.op_b = b;
    for (int i = 0; i < 20 && !done; i++) begin
      done = bus.op_ready;
      @(posedge clk); #1;
    end
    bus.op_valid = 1'b0;
    if (!done) chk({tag, "_accept"}, 0, 1);
  endtask

  task automatic wait_result(input string tag, input logic [15:0] x_res,
                             input logic x_ovf, x_div0, input int x_lat);
    int lat;
    lat = 0;
    while (!bus.res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},  lat,        x_lat);
    chk({tag, "_res"},  bus.result, x_res);
    chk({tag, "_ovf"},  bus.ovf,    x_ovf);
    chk({tag, "_div0"}, bus.div0,   x_div0);
  endtask

  task automatic handshake(input string tag);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({tag, "_rdy_next"}, bus.op_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a, b,
                        input logic [15:0] x_res, input logic x_ovf, x_div0, input int x_lat);
    issue(tag, op, a, b);
    wait_result(tag, x_res, x_ovf, x_div0, x_lat);
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.op_ready, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_res",   bus.result, 0);
    clear = 1'b0;
    #1;
    chk("post_rst_ready", bus.op_ready, 1);
    @(posedge clk); #1;

    run_op("add",    OP_ADD, 16'h0140, 16'h00A0, 16'h01E0, 1'b0, 1'b0, 1);
    run_op("sub",    OP_SUB, 16'h0100, 16'h0300, 16'hFE00, 1'b0, 1'b0, 1);
    run_op("mul_mn", OP_MUL, 16'h8000, 16'h0040, 16'h8000, 1'b0, 1'b0, 17);
    run_op("div",    OP_DIV, 16'h01C0, 16'h0080, 16'h00E0, 1'b0, 1'b0, 24);
    run_op("div3",   OP_DIV, 16'h0040, 16'h00C0, 16'h0015, 1'b0, 1'b0, 24);
    run_op("divneg", OP_DIV, 16'hFE40, 16'h0080, 16'hFF20, 1'b0, 1'b0, 24);
    run_op("addovf", OP_ADD, 16'h7FC0, 16'h0080, SAT ? 16'h7FFF : 16'h8040, 1'b1, 1'b0, 1);
    run_op("subovf", OP_SUB, 16'h8000, 16'h0040, SAT ? 16'h8000 : 16'h7FC0, 1'b1, 1'b0, 1);
    run_op("mulovf", OP_MUL, 16'h4000, 16'h0100, SAT ? 16'h7FFF : 16'h0000, 1'b1, 1'b0, 17);
    run_op("divovf", OP_DIV, 16'h7FC0, 16'h0001, SAT ? 16'h7FFF : 16'hF000, 1'b1, 1'b0, 24);
    run_op("div0p",  OP_DIV, 16'h0140, 16'h0000, SAT ? 16'h7FFF : 16'h0000, 1'b0, 1'b1, 1);
    run_op("div0n",  OP_DIV, 16'hFF00, 16'h0000, SAT ? 16'h8000 : 16'h0000, 1'b0, 1'b1, 1);
    run_op("inval",  3'b110, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1);

    // Backpressure: result held in DONE while op_valid is ignored
    issue("bp", OP_MUL, 16'h00E0, 16'hFF80);
    wait_result("bp", 16'hFE40, 1'b0, 1'b0, 17);
    bus.op_valid = 1'b1; bus.op_code = OP_ADD; bus.op_a = 16'h0001; bus.op_b = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", bus.res_valid, 1);
      chk("bp_res",   bus.result, 16'hFE40);
      chk("bp_ready", bus.op_ready, 0);
    end
    bus.op_valid = 1'b0;
    handshake("bp");

    // Clear in the middle of a MUL discards it
    issue("clr", OP_MUL, 16'h00E0, 16'hFF80);
    repeat (8) @(posedge clk);
    #1;
    clear = 1'b1;
    #2;
    chk("clr_valid", bus.res_valid, 0);
    chk("clr_busy",  bus.busy, 0);
    chk("clr_res",   bus.result, 0);
    chk("clr_ready", bus.op_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    chk("clr_release_ready", bus.op_ready, 1);
    run_op("clr_add", OP_ADD, 16'h0140, 16'h00A0, 16'h01E0, 1'b0, 1'b0, 1);
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
